// File: rtl/serial_add_arbiter_if.sv
// Request/operand/result bundle between the two requesters and the shared
// bit-serial adder sequencer.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [1:0]       req;
  logic [WIDTH-1:0] opa0;
  logic [WIDTH-1:0] opb0;
  logic [WIDTH-1:0] opa1;
  logic [WIDTH-1:0] opb1;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH:0]   sum_out;

  modport master (
    output ena, req, opa0, opb0, opa1, opb1,
    input  gnt, busy, done, sum_out
  );

  modport slave (
    input  ena, req, opa0, opb0, opa1, opb1,
    output gnt, busy, done, sum_out
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin sequencer sharing one LSB-first bit-serial full adder
// (two half-adder cells plus a carry flop) between two requesters.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_arbiter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_owner;
  logic             r_last;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;
  logic [WIDTH:0]   r_sum_out;

  logic w_h1, w_hc1, w_s, w_hc2, w_c, w_win;

  always_comb begin
    w_h1  = r_sa[0] ^ r_sb[0];
    w_hc1 = r_sa[0] & r_sb[0];
    w_s   = w_h1 ^ r_carry;
    w_hc2 = w_h1 & r_carry;
    w_c   = w_hc1 | w_hc2;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    w_win = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_gnt     <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_sum_out <= '0;
    end else if (bus.ena) begin
      case (r_state)
        S_IDLE: begin
          if (bus.req != '0) begin
            r_sa    <= w_win ? bus.opa1 : bus.opa0;
            r_sb    <= w_win ? bus.opb1 : bus.opb0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_last  <= w_win;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // Capture the final bit and carry directly so the result appears with done.
            r_sum_out <= {w_c, w_s, r_sum[WIDTH-1:1]};
            r_done    <= r_owner ? 2'b10 : 2'b01;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum_out = r_sum_out;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter at WIDTH=8.
module tb_serial_add_arbiter;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [1:0]   done;
    logic [W:0]   sum;
  } exp_t;
  exp_t sb[$];

  serial_add_arbiter_if #(.WIDTH(W)) bus ();
  serial_add_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] d, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.done = d;
    e.sum  = {1'b0, a} + {1'b0, b};
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (bus.done != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.req = '0;
    bus.opa0 = '0; bus.opb0 = '0; bus.opa1 = '0; bus.opb1 = '0;
    tick(); tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %0h expected 0", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h expected 0", bus.busy); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done got %0h expected 0", bus.done); end
    checks++; if (bus.sum_out !== 9'h000) begin errors++; $display("FAIL reset_sum got %0h expected 0", bus.sum_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_req0();
    int n; bit ok; exp_t e;
    bus.req = 2'b01; bus.opa0 = 8'h3C; bus.opb0 = 8'h05;
    push_exp(2'b01, 8'h3C, 8'h05);
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL t1_gnt got %0h expected 1", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %0h expected 1", bus.busy); end
    wait_done(20, n, ok);
    e = sb.pop_front();
    checks++; if (!ok || n != W) begin errors++; $display("FAIL t1_latency got %0d expected %0d", n, W); end
    checks++; if (bus.done !== e.done) begin errors++; $display("FAIL t1_done got %0h expected %0h", bus.done, e.done); end
    checks++; if (bus.sum_out !== e.sum || e.sum !== 9'h041) begin errors++; $display("FAIL t1_sum got %0h expected %0h", bus.sum_out, e.sum); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.done !== 2'b00 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL t1_idle got done=%0h gnt=%0h busy=%0h expected 0/0/0", bus.done, bus.gnt, bus.busy); end
  endtask

  task automatic test_carry_req1();
    int n; bit ok; exp_t e;
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    va[0] = 8'hFF; vb[0] = 8'h01;
    va[1] = 8'hFF; vb[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      bus.req = 2'b10; bus.opa1 = va[i]; bus.opb1 = vb[i];
      push_exp(2'b10, va[i], vb[i]);
      tick();
      checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL t2_gnt[%0d] got %0h expected 2", i, bus.gnt); end
      wait_done(20, n, ok);
      e = sb.pop_front();
      checks++; if (!ok || bus.done !== e.done) begin errors++; $display("FAIL t2_done[%0d] got %0h expected %0h", i, bus.done, e.done); end
      checks++; if (bus.sum_out !== e.sum) begin errors++; $display("FAIL t2_sum[%0d] got %0h expected %0h", i, bus.sum_out, e.sum); end
      bus.req = 2'b00;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; exp_t e;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.opa0 = 8'h12; bus.opb0 = 8'h34; bus.opa1 = 8'hA0; bus.opb1 = 8'h7F;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(2'b01, 8'h12, 8'h34);
      else            push_exp(2'b10, 8'hA0, 8'h7F);
    end
    for (int k = 0; k < 4; k++) begin
      int gap;
      wait_done(20, n, ok);
      gap = (k == 0) ? n : n + 1;
      e = sb.pop_front();
      checks++; if (!ok || gap != ((k == 0) ? W + 1 : W + 2)) begin
        errors++; $display("FAIL t3_period[%0d] got %0d expected %0d", k, gap, (k == 0) ? W + 1 : W + 2); end
      checks++; if (bus.done !== e.done) begin errors++; $display("FAIL t3_done[%0d] got %0h expected %0h", k, bus.done, e.done); end
      checks++; if (bus.sum_out !== e.sum) begin errors++; $display("FAIL t3_sum[%0d] got %0h expected %0h", k, bus.sum_out, e.sum); end
      tick();
      checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL t3_pulse[%0d] got %0h expected 0", k, bus.done); end
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_req_drop();
    int n; bit ok; exp_t e;
    bus.req = 2'b01; bus.opa0 = 8'h5A; bus.opb0 = 8'h33;
    push_exp(2'b01, 8'h5A, 8'h33);
    tick();
    tick(); tick(); tick();
    bus.req = 2'b00; bus.opa0 = 8'h00;
    wait_done(20, n, ok);
    e = sb.pop_front();
    checks++; if (!ok || n != W - 3) begin errors++; $display("FAIL t4_latency got %0d expected %0d", n, W - 3); end
    checks++; if (bus.done !== e.done) begin errors++; $display("FAIL t4_done got %0h expected %0h", bus.done, e.done); end
    checks++; if (bus.sum_out !== e.sum) begin errors++; $display("FAIL t4_sum got %0h expected %0h", bus.sum_out, e.sum); end
    tick();
  endtask

  task automatic test_ena_pause();
    int n; bit ok; exp_t e;
    logic [W:0] held;
    bus.req = 2'b10; bus.opa1 = 8'h77; bus.opb1 = 8'h99;
    push_exp(2'b10, 8'h77, 8'h99);
    tick();
    tick(); tick(); tick();
    held = bus.sum_out;
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.sum_out !== held || bus.busy !== 1'b1 || bus.gnt !== 2'b10 || bus.done !== 2'b00) begin
        errors++; $display("FAIL t5_hold[%0d] got sum=%0h busy=%0h gnt=%0h done=%0h expected %0h/1/2/0",
                           i, bus.sum_out, bus.busy, bus.gnt, bus.done, held); end
    end
    bus.ena = 1'b1;
    bus.req = 2'b00;
    wait_done(20, n, ok);
    e = sb.pop_front();
    checks++; if (!ok || n != W - 3) begin errors++; $display("FAIL t5_latency got %0d expected %0d", n, W - 3); end
    checks++; if (bus.done !== e.done) begin errors++; $display("FAIL t5_done got %0h expected %0h", bus.done, e.done); end
    checks++; if (bus.sum_out !== e.sum) begin errors++; $display("FAIL t5_sum got %0h expected %0h", bus.sum_out, e.sum); end
    tick();
  endtask

  task automatic test_reset_abort();
    int n; bit ok; exp_t e;
    bus.req = 2'b10; bus.opa1 = 8'h11; bus.opb1 = 8'h22;
    push_exp(2'b10, 8'h11, 8'h22);
    tick();
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.sum_out !== 9'h000) begin
      errors++; $display("FAIL t6_abort got gnt=%0h busy=%0h sum=%0h expected 0/0/0", bus.gnt, bus.busy, bus.sum_out); end
    bus.req = 2'b00;
    tick();
    rst_n = 1'b1;
    wait_done(12, n, ok);
    checks++; if (ok) begin errors++; $display("FAIL t6_nodone got done=%0h expected 0", bus.done); end
    bus.req = 2'b11; bus.opa0 = 8'h80; bus.opb0 = 8'h80;
    push_exp(2'b01, 8'h80, 8'h80);
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL t6_rr_restart got %0h expected 1", bus.gnt); end
    bus.req = 2'b00;
    wait_done(20, n, ok);
    e = sb.pop_front();
    checks++; if (!ok || bus.done !== e.done || bus.sum_out !== e.sum) begin
      errors++; $display("FAIL t6_sum got done=%0h sum=%0h expected %0h/%0h", bus.done, bus.sum_out, e.done, e.sum); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_carry_req1();
    test_back_to_back();
    test_req_drop();
    test_ena_pause();
    test_reset_abort();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
